bbus_seq_mux: RTL and testbench
===============================

BBUS_SEQ_MUX -- requirements
Module: bbus_seq_mux

Interface
REQ-001 Parameter DATA_W, default 16: B-bus and source word width.
REQ-002 Parameter NARROW_W, default 8: valid width of narrow (RAM-type) sources; the legal range SHALL be 1..DATA_W.
REQ-003 Parameter NSRC, default 8: number of bus sources; the legal range SHALL be 2..16. SEL_W SHALL be $clog2(NSRC).
REQ-004 Parameter NARROW_MASK, default 8'b1000_0001: bit i set means source i is narrow, and only its low NARROW_W bits are meaningful.
REQ-005 Parameter WAIT_MASK, default 8'b1000_0001: bit i set means source i requires MEM_WAIT wait cycles before capture.
REQ-006 Parameter MEM_WAIT, default 2: number of wait cycles; the legal range SHALL be 0..15, and 0 means no source waits.
REQ-007 clk  in  1  system clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 sel_valid  in  1  a source-select request is present.
REQ-010 sel  in  SEL_W  index of the requested source.
REQ-011 sext  in  1  for narrow sources, 1 means sign-extend and 0 means zero-extend.
REQ-012 src_bus  in  NSRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
REQ-013 sel_ready  out  1  the block can accept a request this cycle.
REQ-014 B_bus  out  DATA_W  registered bus value.
REQ-015 bus_valid  out  1  one-cycle pulse marking that B_bus has just been updated.
REQ-016 sel_err  out  1  one-cycle pulse marking that a request was rejected.
REQ-017 cur_sel  out  SEL_W  index of the source most recently accepted.

Function
REQ-018 The block SHALL have two states: IDLE and WAIT.
REQ-019 A request SHALL be accepted on any rising edge where sel_valid=1 and sel_ready=1.
REQ-020 sel_ready SHALL equal 1 exactly when the block is in IDLE.
REQ-021 Out-of-range request (sel >= NSRC) at accept:
- sel_err=1 for the next cycle.
- B_bus, cur_sel and state are unchanged.
- bus_valid stays 0.
REQ-022 Immediate request (sel in range and (WAIT_MASK[sel]=0 or MEM_WAIT=0)) at accept:
- B_bus is loaded with the extended source value at that edge.
- bus_valid=1 for the next cycle.
- cur_sel<=sel, and the block stays in IDLE, so requests can be accepted back to back every cycle.
REQ-023 Wait request (sel in range, WAIT_MASK[sel]=1, MEM_WAIT>0) at accept:
- sel is latched into cur_sel and sext is latched.
- wait counter <= MEM_WAIT-1, and the block goes to WAIT.
REQ-024 In WAIT, on each edge where the counter is non-zero, the counter SHALL decrement by 1.
REQ-025 In WAIT, on the edge where the counter is zero:
- B_bus is loaded from source cur_sel, sampled at that edge, using the latched sext.
- bus_valid=1 for the next cycle, and the block returns to IDLE.
REQ-026 Total latency for a wait request SHALL be MEM_WAIT edges from accept to capture; bus_valid rises after edge T0+MEM_WAIT.
REQ-027 Requests presented while sel_ready=0 SHALL be ignored; the requester holds sel_valid until accepted.
REQ-028 Extension rule:
- A narrow source yields its low NARROW_W bits, padded above with zeros (sext=0) or with copies of bit NARROW_W-1 (sext=1).
- A wide source passes through unmodified and ignores sext.
- When NARROW_W=DATA_W, extension is a no-op.
REQ-029 Between captures, B_bus SHALL hold its last value, irrespective of changes on src_bus.
REQ-030 bus_valid and sel_err SHALL never be 1 in the same cycle.

Reset
REQ-031 While rst_n=0, regardless of clk:
- state=IDLE and wait counter=0.
- B_bus=0, bus_valid=0, sel_err=0, cur_sel=0, sel_ready=1.
REQ-032 Reset asserted during WAIT SHALL abort the pending capture; no bus_valid pulse follows deassertion.
REQ-033 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 Defaults; on consecutive cycles request sel=1 (PC=16'h1234), then sel=6 (AC=16'hBEEF) -> B_bus=1234 then BEEF, with bus_valid high two consecutive cycles and sel_ready constantly 1.
REQ-035 Request sel=0 with source 0=16'hFF85 and sext=0 -> sel_ready=0 for 2 cycles, then B_bus=16'h0085 with a single bus_valid pulse two edges after accept.
REQ-036 Same stimulus as REQ-035 with sext=1, and source 0 changed to 16'h0081 during WAIT -> B_bus=16'hFF81 (sampled at capture edge).
REQ-037 NSRC=6 build, request sel=7 -> one sel_err pulse; B_bus, cur_sel and bus_valid unchanged.
REQ-038 Accept sel=7 (IRAM), assert rst_n=0 one cycle later -> outputs go to reset values immediately, and no bus_valid follows release.
REQ-039 MEM_WAIT=0 build, request sel=0 -> capture on accept edge, with bus_valid the next cycle and no WAIT entry.

Source files
------------

// File: rtl/bbus_seq_mux.sv
// B-bus source multiplexer: selects one of NSRC sources into a registered bus,
// zero/sign-extending narrow sources and inserting wait cycles for slow ones.
module bbus_seq_mux #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NARROW_W    = 8,
    parameter int unsigned NSRC        = 8,
    parameter logic [15:0] NARROW_MASK = 16'h0081,
    parameter logic [15:0] WAIT_MASK   = 16'h0081,
    parameter int unsigned MEM_WAIT    = 2,
    localparam int unsigned SEL_W      = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sel_valid,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   sext,
    input  logic [NSRC*DATA_W-1:0] src_bus,
    output logic                   sel_ready,
    output logic [DATA_W-1:0]      B_bus,
    output logic                   bus_valid,
    output logic                   sel_err,
    output logic [SEL_W-1:0]       cur_sel
);

    localparam int unsigned CNT_W = 4;
    localparam logic [DATA_W-1:0] LOW_MASK = ~({DATA_W{1'b1}} << NARROW_W);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic                sext_q, sext_d;

    logic [DATA_W-1:0]   src_w [NSRC];
    logic                sel_in_range;
    logic                sel_waits;

    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_w[i] = src_bus[i*DATA_W +: DATA_W];
        end
    end

    function automatic logic mask_at(input logic [15:0] m, input logic [SEL_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(idx) == i) r = m[i];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0] idx);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (32'(idx) == i) r = src_w[i];
        end
        return r;
    endfunction

    // Narrow sources keep their low NARROW_W bits and pad above with zeros or the sign bit.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] w,
                                                 input logic narrow, input logic sx);
        logic [DATA_W-1:0] r;
        r = w;
        if (narrow) begin
            r = (w & LOW_MASK) | ((sx && w[NARROW_W-1]) ? ~LOW_MASK : '0);
        end
        return r;
    endfunction

    assign sel_in_range = (32'(sel) < NSRC);
    assign sel_waits    = mask_at(WAIT_MASK, sel) && (MEM_WAIT != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cur_sel_q <= '0;
            sext_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cur_sel_q <= cur_sel_d;
            sext_q    <= sext_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_d     = bus_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cur_sel_d = cur_sel_q;
        sext_d    = sext_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (!sel_in_range) begin
                        err_d = 1'b1;
                    end else if (!sel_waits) begin
                        bus_d     = extend(pick(sel), mask_at(NARROW_MASK, sel), sext);
                        valid_d   = 1'b1;
                        cur_sel_d = sel;
                    end else begin
                        cur_sel_d = sel;
                        sext_d    = sext;
                        cnt_d     = CNT_W'(MEM_WAIT - 1);
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                // The source is sampled on the final wait edge, not at accept.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    bus_d   = extend(pick(cur_sel_q), mask_at(NARROW_MASK, cur_sel_q), sext_q);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_ready = (state_q == IDLE);
    assign B_bus     = bus_q;
    assign bus_valid = valid_q;
    assign sel_err   = err_q;
    assign cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_bbus_seq_mux.sv
// Scoreboard bench for bbus_seq_mux: a default build (waits, narrow sources) and an
// NSRC=6 / MEM_WAIT=0 build (out-of-range selects, zero-wait capture).
module tb_bbus_seq_mux;

    typedef struct {
        bit          err;
        logic [15:0] b;
        logic [2:0]  cs;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel_valid [2];
    logic [2:0]  sel       [2];
    logic        sext      [2];
    logic [15:0] src       [2][8];
    logic [127:0] flat0;
    logic [95:0]  flat1;
    logic        sel_ready [2];
    logic        bus_valid [2];
    logic        sel_err   [2];
    logic [15:0] bbus      [2];
    logic [2:0]  cur_sel   [2];

    int          nsrc_p [2] = '{8, 6};
    int          mw_p   [2] = '{2, 0};
    logic [15:0] nmask_p[2] = '{16'h0081, 16'h0021};
    logic [15:0] wmask_p[2] = '{16'h0081, 16'h0081};

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] held  [2] = '{16'h0, 16'h0};
    logic [15:0] mlast [2] = '{16'h0, 16'h0};
    logic [2:0]  mcs   [2] = '{3'd0, 3'd0};
    int          compared   = 0;
    int          mismatched = 0;

    always_comb begin
        for (int i = 0; i < 8; i++) flat0[i*16 +: 16] = src[0][i];
        for (int i = 0; i < 6; i++) flat1[i*16 +: 16] = src[1][i];
    end

    bbus_seq_mux #(.NSRC(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid[0]), .sel(sel[0]), .sext(sext[0]),
        .src_bus(flat0), .sel_ready(sel_ready[0]), .B_bus(bbus[0]), .bus_valid(bus_valid[0]),
        .sel_err(sel_err[0]), .cur_sel(cur_sel[0])
    );

    bbus_seq_mux #(.NSRC(6), .MEM_WAIT(0), .NARROW_MASK(16'h0021)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid[1]), .sel(sel[1]), .sext(sext[1]),
        .src_bus(flat1), .sel_ready(sel_ready[1]), .B_bus(bbus[1]), .bus_valid(bus_valid[1]),
        .sel_err(sel_err[1]), .cur_sel(cur_sel[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference extension: narrow sources keep the low byte, padded by zeros or its sign.
    function automatic logic [15:0] ref_ext(input int d, input int s, input logic [15:0] w,
                                            input logic x);
        if (((nmask_p[d] >> s) & 16'h1) == 16'h0) return w;
        if (x && w[7]) return {8'hFF, w[7:0]};
        return {8'h00, w[7:0]};
    endfunction

    task automatic idle(input int d, input int n);
        sel_valid[d] = 1'b0;
        sel[d]       = 3'($urandom_range(0, 7));
        repeat (n) @(negedge clk);
    endtask

    // Issue one request from a negedge; returns on a negedge with the DUT ready again.
    task automatic req(input int d, input logic [2:0] s, input logic x, input bit rnd,
                       input bit chg, input logic [15:0] nv);
        exp_t        e;
        int          n;
        bit          waits;
        logic [15:0] w;
        sel_valid[d] = 1'b1;
        sel[d]       = s;
        sext[d]      = x;
        n = 0;
        while (!sel_ready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sel_ready[d]) begin
            chk("ready_timeout", 32'(sel_ready[d]), 32'd1);
            sel_valid[d] = 1'b0;
            return;
        end
        if (rnd) for (int i = 0; i < 8; i++) src[d][i] = 16'($urandom);
        waits = (int'(s) < nsrc_p[d]) && (((wmask_p[d] >> s) & 16'h1) != 16'h0) && (mw_p[d] > 0);
        w = (chg && waits) ? nv : src[d][s];
        if (int'(s) >= nsrc_p[d]) begin
            e = '{1'b1, mlast[d], mcs[d]};
        end else begin
            e = '{1'b0, ref_ext(d, int'(s), w, x), s};
            mlast[d] = e.b;
            mcs[d]   = s;
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (waits) begin
            if (chg) src[d][s] = nv;
            n = 0;
            while (!sel_ready[d] && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("wait_len", 32'(n), 32'(mw_p[d]));
        end else begin
            chk("ready_imm", 32'(sel_ready[d]), 32'd1);
        end
    endtask

    // Monitor: every bus_valid/sel_err pulse consumes one expected entry; otherwise B_bus must hold.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                held[d] <= 16'h0;
                if (d == 0) q0.delete();
                else        q1.delete();
            end else begin
                if (bus_valid[d] && sel_err[d]) chk("pulse_overlap", 32'd1, 32'd0);
                if (bus_valid[d] || sel_err[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("unexpected_pulse_dut%0d", d), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("err_flag_dut%0d", d), 32'(sel_err[d]), 32'(e.err));
                        chk($sformatf("b_bus_dut%0d", d), 32'(bbus[d]), 32'(e.b));
                        chk($sformatf("cur_sel_dut%0d", d), 32'(cur_sel[d]), 32'(e.cs));
                        held[d] <= e.b;
                    end
                end else begin
                    chk($sformatf("b_hold_dut%0d", d), 32'(bbus[d]), 32'(held[d]));
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_b_bus"},     32'(bbus[d]),      32'd0);
            chk({tag, "_bus_valid"}, 32'(bus_valid[d]), 32'd0);
            chk({tag, "_sel_err"},   32'(sel_err[d]),   32'd0);
            chk({tag, "_cur_sel"},   32'(cur_sel[d]),   32'd0);
            chk({tag, "_sel_ready"}, 32'(sel_ready[d]), 32'd1);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel_valid[d] = 1'b0;
            sel[d]       = 3'd0;
            sext[d]      = 1'b0;
            for (int i = 0; i < 8; i++) src[d][i] = 16'($urandom);
        end
        repeat (2) @(negedge clk);
        chk_reset("reset");

        // Back-to-back immediate captures, first one on the edge right after release.
        src[0][1] = 16'h1234;
        src[0][6] = 16'hBEEF;
        rst_n = 1'b1;
        req(0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0);
        req(0, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0);
        idle(0, 2);

        // Narrow wait source, zero- then sign-extended, second one changed mid-wait.
        src[0][0] = 16'hFF85;
        req(0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(0, 1);
        src[0][0] = 16'hFF85;
        req(0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0081);
        idle(0, 1);

        for (int k = 0; k < 200; k++) begin
            req(0, 3'($urandom_range(0, 7)), 1'($urandom), 1'b1, 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(1, 3));
        end
        idle(0, 3);

        // Reset one cycle into a wait on source 7: outputs clear at once, capture is lost.
        for (int i = 0; i < 8; i++) src[0][i] = 16'($urandom) | 16'h0101;
        sel_valid[0] = 1'b1;
        sel[0]       = 3'd7;
        sext[0]      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        mlast[0] = 16'h0;
        mcs[0]   = 3'd0;
        mlast[1] = 16'h0;
        mcs[1]   = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Second build: out-of-range selects and zero-wait capture.
        req(1, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0);
        req(1, 3'd7, 1'b0, 1'b1, 1'b0, 16'h0);
        req(1, 3'd6, 1'b0, 1'b1, 1'b0, 16'h0);
        src[1][0] = 16'h1280;
        req(1, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 150; k++) begin
            req(1, 3'($urandom_range(0, 7)), 1'($urandom), 1'b1, 1'b0, 16'h0);
            if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(1, 3));
        end
        idle(1, 3);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
